// File: rtl/jam_cost_loader.sv
// jam_cost_loader
//   Loads a 64-entry (8 workers x 8 jobs) cost table from a valid/ready
//   stream, computes the sum of the per-worker row minima as a lower bound,
//   then releases the JAM solver from reset. The solver reads costs through
//   W/J and, when it reports Valid, the result is latched and held.
//
// Ports
//   CLK              clock, rising edge
//   RST_N            asynchronous active-low reset
//   start            begin a new load (accepted in IDLE and DONE only)
//   in_valid/in_data cost entry stream, row-major (worker-major), 7 bits
//   in_ready         registered; high only while loading
//   W, J             worker/job index from JAM
//   Cost             combinational read of table[8*W+J]
//   jam_rst          registered active-high reset to JAM, low only in RUN
//   jam_valid        JAM result valid
//   jam_min_cost     JAM MinCost
//   jam_match_count  JAM MatchCount
//   lower_bound      sum of the 8 row minima
//   min_cost_out     latched MinCost
//   match_count_out  latched MatchCount
//   done             result latched and stable
module jam_cost_loader (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       in_valid,
  input  logic [6:0] in_data,
  output logic       in_ready,
  input  logic [2:0] W,
  input  logic [2:0] J,
  output logic [6:0] Cost,
  output logic       jam_rst,
  input  logic       jam_valid,
  input  logic [9:0] jam_min_cost,
  input  logic [3:0] jam_match_count,
  output logic [9:0] lower_bound,
  output logic [9:0] min_cost_out,
  output logic [3:0] match_count_out,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [5:0] idx_reg;
  logic [6:0] row_min_reg;
  logic [9:0] lower_bound_reg;
  logic [9:0] min_cost_reg;
  logic [3:0] match_count_reg;
  logic       in_ready_reg;
  logic       jam_rst_reg;
  logic       done_reg;

  logic [6:0] cost_table [0:63];

  logic       accept;
  logic       load_begin;
  logic       row_last;
  logic       result_take;
  logic [6:0] cur_min;

  // in_ready_reg is high exactly while state_reg is LOAD, so it doubles as
  // the LOAD qualifier for acceptance.
  assign accept      = in_valid && in_ready_reg;
  assign load_begin  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign row_last    = (idx_reg[2:0] == 3'd7);
  assign result_take = (state_reg == RUN) && jam_valid;
  assign cur_min     = (in_data < row_min_reg) ? in_data : row_min_reg;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: if (accept && (idx_reg == 6'd63)) state_next = RUN;
      RUN:  if (jam_valid) state_next = DONE;
      DONE: if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered control outputs. The control outputs are
  // derived from state_next so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b0;
      jam_rst_reg  <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == LOAD);
      jam_rst_reg  <= (state_next != RUN);
      done_reg     <= (state_next == DONE);
    end
  end

  // Load datapath: index counter, running row minimum, lower bound.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_reg         <= 6'd0;
      row_min_reg     <= 7'd127;
      lower_bound_reg <= 10'd0;
    end else if (load_begin) begin
      idx_reg         <= 6'd0;
      row_min_reg     <= 7'd127;
      lower_bound_reg <= 10'd0;
    end else if (accept) begin
      // idx wraps to 0 after the 64th entry.
      idx_reg <= idx_reg + 6'd1;
      if (row_last) begin
        lower_bound_reg <= lower_bound_reg + {3'd0, cur_min};
        row_min_reg     <= 7'd127;
      end else begin
        row_min_reg <= cur_min;
      end
    end
  end

  // Result capture; only honoured in RUN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      min_cost_reg    <= 10'd0;
      match_count_reg <= 4'd0;
    end else if (result_take) begin
      min_cost_reg    <= jam_min_cost;
      match_count_reg <= jam_match_count;
    end
  end

  // Table storage has no reset: every LOAD rewrites all 64 entries.
  always_ff @(posedge CLK) begin
    if (accept) cost_table[idx_reg] <= in_data;
  end

  // {W,J} == 8*W+J
  assign Cost = cost_table[{W, J}];

  assign in_ready        = in_ready_reg;
  assign jam_rst         = jam_rst_reg;
  assign done            = done_reg;
  assign lower_bound     = lower_bound_reg;
  assign min_cost_out    = min_cost_reg;
  assign match_count_out = match_count_reg;

endmodule

// File: tb/tb_jam_cost_loader.sv
// Testbench for jam_cost_loader: directed sequence with a scoreboard queue
// of expected table contents that is drained by reading back via W/J.
module tb_jam_cost_loader;

  logic       CLK;
  logic       RST_N;
  logic       start;
  logic       in_valid;
  logic [6:0] in_data;
  logic       in_ready;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       jam_rst;
  logic       jam_valid;
  logic [9:0] jam_min_cost;
  logic [3:0] jam_match_count;
  logic [9:0] lower_bound;
  logic [9:0] min_cost_out;
  logic [3:0] match_count_out;
  logic       done;

  int checks   = 0;
  int failures = 0;

  int exp_q[$];
  int tbl_model[64];

  jam_cost_loader dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .start           (start),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .W               (W),
    .J               (J),
    .Cost            (Cost),
    .jam_rst         (jam_rst),
    .jam_valid       (jam_valid),
    .jam_min_cost    (jam_min_cost),
    .jam_match_count (jam_match_count),
    .lower_bound     (lower_bound),
    .min_cost_out    (min_cost_out),
    .match_count_out (match_count_out),
    .done            (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int gen_val(input int mode, input int k);
    case (mode)
      0:       return 5;
      1:       return (k * 13) % 100;
      default: return (k * 7 + 3) % 128;
    endcase
  endfunction

  function automatic int golden_lb();
    int sum = 0;
    for (int r = 0; r < 8; r++) begin
      int m = 127;
      for (int c = 0; c < 8; c++)
        if (tbl_model[r*8+c] < m) m = tbl_model[r*8+c];
      sum += m;
    end
    return sum;
  endfunction

  // Offer entries base..base+n-1; gaps=1 drops in_valid about half the time.
  task automatic load_n(input int n, input int base, input int mode, input bit gaps);
    int acc = 0;
    int cyc = 0;
    bit got;
    while (acc < n && cyc < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 7'(gen_val(mode, base + acc));
      got      = in_valid && in_ready;
      tick();
      if (got) begin
        tbl_model[base + acc] = gen_val(mode, base + acc);
        exp_q.push_back(gen_val(mode, base + acc));
        acc++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_accept_count", acc, n);
    $display("load: %0d entries accepted from base %0d mode %0d in %0d cycles", acc, base, mode, cyc);
  endtask

  task automatic readback();
    int exp;
    for (int k = 0; k < 64; k++) begin
      W = 3'(k / 8);
      J = 3'(k % 8);
      #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        exp = exp_q.pop_front();
        chk($sformatf("cost_w%0d_j%0d", k / 8, k % 8), Cost, exp);
      end
    end
    $display("readback: 64 table entries compared");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    W = '0; J = '0; jam_valid = 1'b0; jam_min_cost = '0; jam_match_count = '0;
    repeat (3) tick();
    RST_N = 1'b1;

    // Idle after reset, no start
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_jam_rst", jam_rst, 1);
      chk("idle_done", done, 0);
      chk("idle_lower_bound", lower_bound, 0);
      chk("idle_min_cost_out", min_cost_out, 0);
    end
    $display("idle: 20 cycles held reset values");

    // Constant-5 table, back to back
    pulse_start();
    chk("load_in_ready", in_ready, 1);
    chk("load_jam_rst", jam_rst, 1);
    load_n(64, 0, 0, 1'b0);
    chk("run_jam_rst", jam_rst, 0);
    chk("run_in_ready", in_ready, 0);
    chk("run_lb_const5", lower_bound, 40);
    W = 3'd3; J = 3'd4; #1;
    chk("cost_w3_j4", Cost, 5);
    readback();

    // start during RUN is ignored
    pulse_start();
    chk("run_start_ignored_in_ready", in_ready, 0);
    chk("run_start_ignored_jam_rst", jam_rst, 0);
    chk("run_start_ignored_done", done, 0);

    // JAM reports result
    jam_valid = 1'b1; jam_min_cost = 10'd40; jam_match_count = 4'd3;
    tick();
    jam_valid = 1'b0;
    chk("done_flag", done, 1);
    chk("done_min_cost", min_cost_out, 40);
    chk("done_match_count", match_count_out, 3);
    chk("done_jam_rst", jam_rst, 1);
    $display("result: min_cost_out=%0d match_count_out=%0d", min_cost_out, match_count_out);

    // jam_valid outside RUN ignored; outputs held in DONE
    jam_valid = 1'b1; jam_min_cost = 10'd999; jam_match_count = 4'd9;
    repeat (5) tick();
    jam_valid = 1'b0;
    chk("hold_done", done, 1);
    chk("hold_min_cost", min_cost_out, 40);
    chk("hold_match_count", match_count_out, 3);
    chk("hold_lower_bound", lower_bound, 40);

    // start in DONE -> LOAD, gappy stream
    pulse_start();
    chk("reload_done", done, 0);
    chk("reload_lower_bound", lower_bound, 0);
    chk("reload_in_ready", in_ready, 1);
    load_n(64, 0, 1, 1'b1);
    chk("gap_jam_rst", jam_rst, 0);
    chk("gap_lower_bound", lower_bound, golden_lb());
    readback();

    // Finish this run, then reset in the middle of a load
    jam_valid = 1'b1; jam_min_cost = 10'd123; jam_match_count = 4'd7;
    tick();
    jam_valid = 1'b0;
    chk("second_done", done, 1);
    chk("second_min_cost", min_cost_out, 123);
    pulse_start();
    load_n(30, 0, 1, 1'b0);
    exp_q.delete();
    #2;
    RST_N = 1'b0;
    #1;
    chk("areset_in_ready", in_ready, 0);
    chk("areset_jam_rst", jam_rst, 1);
    chk("areset_done", done, 0);
    chk("areset_lower_bound", lower_bound, 0);
    chk("areset_min_cost", min_cost_out, 0);
    chk("areset_match_count", match_count_out, 0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("post_reset_in_ready", in_ready, 0);
    pulse_start();
    load_n(63, 0, 2, 1'b0);
    chk("63_still_loading", in_ready, 1);
    chk("63_jam_rst", jam_rst, 1);
    load_n(1, 63, 2, 1'b0);
    chk("64_run_jam_rst", jam_rst, 0);
    chk("64_run_in_ready", in_ready, 0);
    chk("64_lower_bound", lower_bound, golden_lb());
    readback();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
